// File: rtl/red_pitaya_sort_pulser.sv
// red_pitaya_sort_pulser: delayed bipolar square-wave burst on a DAC stream, fired by the sort trigger
module red_pitaya_sort_pulser #(
  parameter int DWT = 14,
  parameter int MEM = 32
) (
  input  logic                  adc_clk_i,
  input  logic                  adc_rst_i,
  input  logic                  sort_trig_i,
  output logic signed [DWT-1:0] dac_o,
  output logic                  busy_o,
  input  logic [31:0]           sys_addr,
  input  logic [31:0]           sys_wdata,
  input  logic [3:0]            sys_sel,
  input  logic                  sys_wen,
  input  logic                  sys_ren,
  output logic [31:0]           sys_rdata,
  output logic                  sys_err,
  output logic                  sys_ack
);
  typedef enum logic [1:0] {IDLE = 2'd0, DLY = 2'd1, BURST = 2'd2} state_t;
  localparam logic signed [DWT-1:0] AMAX = {1'b0, {(DWT-1){1'b1}}};
  localparam logic signed [DWT-1:0] AMIN = {1'b1, {(DWT-1){1'b0}}};
  state_t state, state_n;
  logic trig_q, trig_edge, abort, accept, miss, half_end, last, enter_burst;
  logic enable;
  logic [MEM-1:0] delay, pulse_cnt, missed_cnt, dcnt;
  logic [15:0] half, ncyc, sh_half, sh_n, hcnt, ccnt;
  logic signed [DWT-1:0] amp, amp_pos, amp_neg, sh_pos, sh_neg;
  logic [DWT:0] neg_w;
  logic phase;
  logic [19:0] a;
  logic [31:0] rd_mux;
  logic unused;
  assign a = sys_addr[19:0];
  assign unused = ^{sys_sel, sys_addr[31:20]};
  assign sys_err = 1'b0;
  assign busy_o = state != IDLE;
  assign trig_edge = sort_trig_i & ~trig_q;
  assign abort = sys_wen && a == 20'h00 && sys_wdata[1];
  assign accept = trig_edge && enable && state == IDLE && !abort;
  assign miss = trig_edge && state != IDLE && !abort;
  assign half_end = hcnt == sh_half - 16'd1;
  assign last = phase && ccnt == sh_n - 16'd1;
  assign enter_burst = state_n == BURST && state != BURST;
  // Amplitude pair: the most-negative code has no positive twin, so both polarities clamp to full scale
  always_comb begin
    neg_w = '0 - {amp[DWT-1], amp};
    amp_pos = (amp == AMIN) ? AMAX : amp;
    amp_neg = (neg_w[DWT] != neg_w[DWT-1]) ? AMAX : neg_w[DWT-1:0];
  end
  // Next state; an abort write overrides every transition
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = (delay == '0) ? BURST : DLY;
      DLY:     if (dcnt == MEM'(1)) state_n = BURST;
      BURST:   if (half_end && last) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (abort) state_n = IDLE;
  end
  // State register
  always_ff @(posedge adc_clk_i) begin
    if (adc_rst_i) state <= IDLE;
    else state <= state_n;
  end
  // Shadow snapshot, delay/half/period counters and the registered DAC sample
  always_ff @(posedge adc_clk_i) begin
    if (adc_rst_i) begin
      dcnt <= '0;
      sh_half <= 16'd1;
      sh_n <= 16'd1;
      sh_pos <= '0;
      sh_neg <= '0;
      hcnt <= '0;
      ccnt <= '0;
      phase <= 1'b0;
      dac_o <= '0;
    end else begin
      if (accept) begin
        dcnt <= delay;
        sh_half <= (half == '0) ? 16'd1 : half;
        sh_n <= (ncyc == '0) ? 16'd1 : ncyc;
        sh_pos <= amp_pos;
        sh_neg <= amp_neg;
      end else if (state == DLY) begin
        dcnt <= dcnt - MEM'(1);
      end
      hcnt <= (state == BURST && !half_end) ? hcnt + 16'd1 : '0;
      phase <= (state == BURST) && (phase ^ half_end);
      ccnt <= (state == BURST) ? ccnt + 16'(half_end && phase) : '0;
      dac_o <= (state_n != BURST) ? '0 :
               enter_burst ? ((state == IDLE) ? amp_pos : sh_pos) :
               half_end ? (phase ? sh_pos : sh_neg) : dac_o;
    end
  end
  // Live configuration, trigger history and statistics; a counter clear beats a same-cycle increment
  always_ff @(posedge adc_clk_i) begin
    if (adc_rst_i) begin
      trig_q <= 1'b0;
      enable <= 1'b0;
      delay <= '0;
      half <= 16'd6250;
      ncyc <= 16'd10;
      amp <= DWT'(4096);
      pulse_cnt <= '0;
      missed_cnt <= '0;
    end else begin
      trig_q <= sort_trig_i;
      if (sys_wen && a == 20'h00) enable <= sys_wdata[0];
      if (sys_wen && a == 20'h04) delay <= sys_wdata[MEM-1:0];
      if (sys_wen && a == 20'h08) half <= sys_wdata[15:0];
      if (sys_wen && a == 20'h0C) ncyc <= sys_wdata[15:0];
      if (sys_wen && a == 20'h10) amp <= sys_wdata[DWT-1:0];
      pulse_cnt <= (sys_wen && a == 20'h14) ? '0 : pulse_cnt + MEM'(accept);
      missed_cnt <= (sys_wen && a == 20'h18) ? '0 : missed_cnt + MEM'(miss);
    end
  end
  // Read decode
  always_comb begin
    rd_mux = '0;
    case (a)
      20'h00:  rd_mux = {31'd0, enable};
      20'h04:  rd_mux = 32'(delay);
      20'h08:  rd_mux = {16'd0, half};
      20'h0C:  rd_mux = {16'd0, ncyc};
      20'h10:  rd_mux = {{(32-DWT){amp[DWT-1]}}, amp};
      20'h14:  rd_mux = 32'(pulse_cnt);
      20'h18:  rd_mux = 32'(missed_cnt);
      20'h1C:  rd_mux = {29'd0, state, busy_o};
      default: rd_mux = '0;
    endcase
  end
  // Bus response, one cycle after the request
  always_ff @(posedge adc_clk_i) begin
    if (adc_rst_i) begin
      sys_ack <= 1'b0;
      sys_rdata <= '0;
    end else begin
      sys_ack <= sys_wen | sys_ren;
      sys_rdata <= sys_ren ? rd_mux : '0;
    end
  end
endmodule

// File: tb/tb_red_pitaya_sort_pulser.sv
// tb_red_pitaya_sort_pulser: randomized and directed checks of the sort pulser against a timing-formula model
module tb_red_pitaya_sort_pulser;
  logic clk = 1'b0, rst = 1'b1, trig = 1'b0;
  logic signed [13:0] dac;
  logic busy, sys_err, sys_ack, sys_wen = 1'b0, sys_ren = 1'b0;
  logic [31:0] sys_addr = '0, sys_wdata = '0, sys_rdata;
  int cyc = 0, checks = 0, failures = 0;
  int cfg_d = 0, cfg_h = 6250, cfg_n = 10, cfg_a = 4096;
  int exp_pulse = 0, exp_missed = 0;
  int m_acc = -1000, m_start = -1000, m_h = 1, m_n = 0, m_pos = 0, m_neg = 0, m_end = -1000;

  red_pitaya_sort_pulser #(.DWT(14), .MEM(32)) dut (
    .adc_clk_i(clk), .adc_rst_i(rst), .sort_trig_i(trig), .dac_o(dac), .busy_o(busy),
    .sys_addr(sys_addr), .sys_wdata(sys_wdata), .sys_sel(4'hF), .sys_wen(sys_wen),
    .sys_ren(sys_ren), .sys_rdata(sys_rdata), .sys_err(sys_err), .sys_ack(sys_ack));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  // Burst of the trigger sampled at cycle t, from the live configuration
  function automatic void arm(int t);
    m_acc = t;
    m_h = (cfg_h == 0) ? 1 : cfg_h;
    m_n = (cfg_n == 0) ? 1 : cfg_n;
    m_start = t + 1 + cfg_d;
    m_end = m_start + 2 * m_h * m_n;
    m_pos = (cfg_a == -8192) ? 8191 : cfg_a;
    m_neg = (-cfg_a > 8191) ? 8191 : -cfg_a;
    exp_pulse++;
  endfunction

  function automatic void disarm();
    m_acc = -1000;
    m_start = -1000;
    m_end = -1000;
  endfunction

  function automatic int exp_dac(int c);
    int k;
    k = c - m_start;
    if (k >= 0 && c < m_end) return ((k / m_h) % 2 == 0) ? m_pos : m_neg;
    return 0;
  endfunction

  function automatic logic exp_busy(int c);
    return c > m_acc && c < m_end;
  endfunction

  task automatic bus_write(input logic [31:0] ad, input logic [31:0] d);
    logic signed [13:0] s;
    sys_addr = ad;
    sys_wdata = d;
    sys_wen = 1'b1;
    @(posedge clk); #1;
    sys_wen = 1'b0;
    s = d[13:0];
    case (ad)
      32'h04: cfg_d = int'(d);
      32'h08: cfg_h = int'(d[15:0]);
      32'h0C: cfg_n = int'(d[15:0]);
      32'h10: cfg_a = int'(s);
      32'h14: exp_pulse = 0;
      32'h18: exp_missed = 0;
      default: ;
    endcase
  endtask

  task automatic bus_read(input logic [31:0] ad, output logic [31:0] d, output logic ack);
    sys_addr = ad;
    sys_ren = 1'b1;
    @(posedge clk); #1;
    sys_ren = 1'b0;
    d = sys_rdata;
    ack = sys_ack;
  endtask

  task automatic config_burst(input int d, input int h, input int n, input int a);
    bus_write(32'h04, 32'(d));
    bus_write(32'h08, 32'(h));
    bus_write(32'h0C, 32'(n));
    bus_write(32'h10, 32'(a));
    bus_write(32'h00, 32'h1);
  endtask

  task automatic test_reset();
    logic [31:0] ad[8] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h1C};
    logic [31:0] ex[8] = '{32'd0, 32'd0, 32'd6250, 32'd10, 32'd4096, 32'd0, 32'd0, 32'd0};
    logic [31:0] d;
    logic ack;
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    checks++;
    if (dac !== 14'd0 || busy !== 1'b0 || sys_ack !== 1'b0 || sys_err !== 1'b0 || sys_rdata !== 32'd0) begin
      failures++;
      $display("FAIL reset_outputs dac=%0d busy=%b ack=%b err=%b rdata=%0h required 0", $signed(dac), busy, sys_ack, sys_err, sys_rdata);
    end
    for (int i = 0; i < 8; i++) begin
      bus_read(ad[i], d, ack);
      checks++;
      if (d !== ex[i] || ack !== 1'b1) begin
        failures++;
        $display("FAIL reset_reg addr=%0h got=%0h ack=%b required=%0h ack=1", ad[i], d, ack, ex[i]);
      end
    end
  endtask

  task automatic test_basic_burst();
    int plan[12] = '{0, 0, 0, 100, 100, -100, -100, 100, 100, -100, -100, 0};
    int t;
    logic [31:0] d;
    logic ack;
    config_burst(3, 2, 2, 100);
    trig = 1'b1;
    t = cyc;
    arm(t);
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      trig = 1'b0;
      checks++;
      if (dac !== 14'(plan[i-1]) || dac !== 14'(exp_dac(cyc)) || busy !== exp_busy(cyc)) begin
        failures++;
        $display("FAIL basic_burst T+%0d dac=%0d busy=%b required dac=%0d busy=%b", i, $signed(dac), busy, plan[i-1], exp_busy(cyc));
      end
    end
    bus_read(32'h14, d, ack);
    checks++;
    if (d !== 32'd1) begin failures++; $display("FAIL basic_pulse_count got=%0d required=1", d); end
  endtask

  task automatic test_missed_and_live_update();
    int t;
    logic [31:0] d;
    logic ack;
    for (int b = 0; b < 2; b++) begin
      sys_addr = 32'h10;
      sys_wdata = 32'd50;
      trig = 1'b1;
      t = cyc;
      arm(t);
      while (cyc < m_end) begin
        @(posedge clk); #1;
        checks++;
        if (dac !== 14'(exp_dac(cyc)) || busy !== exp_busy(cyc)) begin
          failures++;
          $display("FAIL missed_burst%0d cyc=T+%0d dac=%0d busy=%b required dac=%0d busy=%b", b, cyc - t, $signed(dac), busy, exp_dac(cyc), exp_busy(cyc));
        end
        trig = (b == 0) && (cyc - t == 3 || cyc - t == 6);
        sys_wen = (b == 0) && (cyc - t == 4);
      end
      if (b == 0) begin cfg_a = 50; exp_missed += 2; end
    end
    bus_read(32'h18, d, ack);
    checks++;
    if (d !== 32'(exp_missed)) begin failures++; $display("FAIL missed_count got=%0d required=%0d", d, exp_missed); end
    bus_read(32'h14, d, ack);
    checks++;
    if (d !== 32'(exp_pulse)) begin failures++; $display("FAIL missed_pulse_count got=%0d required=%0d", d, exp_pulse); end
  endtask

  task automatic test_disabled_and_saturation();
    int plan[3] = '{8191, 8191, 0};
    int t;
    logic [31:0] d;
    logic ack;
    bus_write(32'h00, 32'h0);
    trig = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
      trig = 1'b0;
      checks++;
      if (dac !== 14'd0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL disabled_idle T+%0d dac=%0d busy=%b required 0", i, $signed(dac), busy);
      end
    end
    bus_read(32'h14, d, ack);
    checks++;
    if (d !== 32'(exp_pulse)) begin failures++; $display("FAIL disabled_pulse got=%0d required=%0d", d, exp_pulse); end
    bus_read(32'h18, d, ack);
    checks++;
    if (d !== 32'(exp_missed)) begin failures++; $display("FAIL disabled_missed got=%0d required=%0d", d, exp_missed); end
    config_burst(0, 0, 0, 32'hFFFF_E000);
    trig = 1'b1;
    t = cyc;
    arm(t);
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      trig = 1'b0;
      checks++;
      if (dac !== 14'(plan[i-1]) || dac !== 14'(exp_dac(cyc)) || busy !== exp_busy(cyc)) begin
        failures++;
        $display("FAIL saturation T+%0d dac=%0d busy=%b required dac=%0d", i, $signed(dac), busy, plan[i-1]);
      end
    end
  endtask

  task automatic test_abort();
    int t;
    logic [31:0] d;
    logic ack;
    config_burst(1, 3, 4, 200);
    sys_addr = 32'h00;
    sys_wdata = 32'h3;
    trig = 1'b1;
    t = cyc;
    arm(t);
    for (int i = 1; i <= 9; i++) begin
      @(posedge clk); #1;
      checks++;
      if (i <= 5 && (dac !== 14'(exp_dac(cyc)) || busy !== exp_busy(cyc))) begin
        failures++;
        $display("FAIL abort_pre T+%0d dac=%0d busy=%b required dac=%0d busy=%b", i, $signed(dac), busy, exp_dac(cyc), exp_busy(cyc));
      end
      if (i > 5 && (dac !== 14'd0 || busy !== 1'b0)) begin
        failures++;
        $display("FAIL abort_post T+%0d dac=%0d busy=%b required 0", i, $signed(dac), busy);
      end
      trig = (i == 5);
      sys_wen = (i == 5);
    end
    disarm();
    bus_read(32'h00, d, ack);
    checks++;
    if (d !== 32'h1) begin failures++; $display("FAIL abort_ctrl got=%0h required=1", d); end
    bus_read(32'h14, d, ack);
    checks++;
    if (d !== 32'(exp_pulse)) begin failures++; $display("FAIL abort_pulse got=%0d required=%0d", d, exp_pulse); end
    bus_read(32'h18, d, ack);
    checks++;
    if (d !== 32'(exp_missed)) begin failures++; $display("FAIL abort_missed got=%0d required=%0d", d, exp_missed); end
  endtask

  task automatic test_reset_mid_burst();
    int t;
    logic [31:0] d;
    logic ack;
    trig = 1'b1;
    t = cyc;
    arm(t);
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      trig = 1'b0;
      checks++;
      if (i <= 4 && (dac !== 14'(exp_dac(cyc)) || busy !== exp_busy(cyc))) begin
        failures++;
        $display("FAIL rst_pre T+%0d dac=%0d busy=%b required dac=%0d", i, $signed(dac), busy, exp_dac(cyc));
      end
      if (i > 4 && (dac !== 14'd0 || busy !== 1'b0)) begin
        failures++;
        $display("FAIL rst_post T+%0d dac=%0d busy=%b required 0", i, $signed(dac), busy);
      end
      rst = (i == 4);
    end
    disarm();
    cfg_d = 0; cfg_h = 6250; cfg_n = 10; cfg_a = 4096;
    exp_pulse = 0; exp_missed = 0;
    bus_read(32'h14, d, ack);
    checks++;
    if (d !== 32'd0) begin failures++; $display("FAIL rst_pulse got=%0d required=0", d); end
    bus_read(32'h18, d, ack);
    checks++;
    if (d !== 32'd0) begin failures++; $display("FAIL rst_missed got=%0d required=0", d); end
    bus_read(32'h00, d, ack);
    checks++;
    if (d !== 32'd0) begin failures++; $display("FAIL rst_ctrl got=%0h required=0", d); end
  endtask

  task automatic test_clear_race();
    int t;
    logic [31:0] d;
    logic ack;
    config_burst(0, 1, 1, 7);
    sys_addr = 32'h14;
    sys_wdata = 32'h0;
    sys_wen = 1'b1;
    trig = 1'b1;
    t = cyc;
    arm(t);
    exp_pulse = 0;
    while (cyc < m_end) begin
      @(posedge clk); #1;
      sys_wen = 1'b0;
      trig = 1'b0;
      checks++;
      if (dac !== 14'(exp_dac(cyc)) || busy !== exp_busy(cyc)) begin
        failures++;
        $display("FAIL clear_race_burst T+%0d dac=%0d required=%0d", cyc - t, $signed(dac), exp_dac(cyc));
      end
    end
    bus_read(32'h14, d, ack);
    checks++;
    if (d !== 32'd0) begin failures++; $display("FAIL clear_race_pulse got=%0d required=0", d); end
  endtask

  task automatic test_unmapped();
    logic [31:0] d;
    logic ack;
    @(posedge clk); #1;
    sys_addr = 32'h20;
    sys_ren = 1'b1;
    checks++;
    if (sys_ack !== 1'b0) begin failures++; $display("FAIL unmapped_ack_early got=%b required=0", sys_ack); end
    @(posedge clk); #1;
    sys_ren = 1'b0;
    checks++;
    if (sys_ack !== 1'b1 || sys_rdata !== 32'd0) begin
      failures++;
      $display("FAIL unmapped_read ack=%b rdata=%0h required ack=1 rdata=0", sys_ack, sys_rdata);
    end
    @(posedge clk); #1;
    checks++;
    if (sys_ack !== 1'b0) begin failures++; $display("FAIL unmapped_ack_drop got=%b required=0", sys_ack); end
    bus_read(32'h1C, d, ack);
    checks++;
    if (d !== 32'd0) begin failures++; $display("FAIL status_idle got=%0h required=0", d); end
  endtask

  task automatic test_random();
    int t;
    logic nt;
    logic [31:0] d;
    logic ack;
    for (int r = 0; r < 10; r++) begin
      config_burst($urandom_range(0, 5), $urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 16383));
      trig = 1'b1;
      t = cyc;
      arm(t);
      while (cyc < m_end) begin
        @(posedge clk); #1;
        checks++;
        if (dac !== 14'(exp_dac(cyc)) || busy !== exp_busy(cyc)) begin
          failures++;
          $display("FAIL random%0d T+%0d dac=%0d busy=%b required dac=%0d busy=%b", r, cyc - t, $signed(dac), busy, exp_dac(cyc), exp_busy(cyc));
        end
        nt = (cyc < m_end) && ($urandom_range(0, 2) == 0);
        if (nt && !trig && exp_busy(cyc)) exp_missed++;
        trig = nt;
      end
    end
    bus_read(32'h14, d, ack);
    checks++;
    if (d !== 32'(exp_pulse)) begin failures++; $display("FAIL random_pulse got=%0d required=%0d", d, exp_pulse); end
    bus_read(32'h18, d, ack);
    checks++;
    if (d !== 32'(exp_missed)) begin failures++; $display("FAIL random_missed got=%0d required=%0d", d, exp_missed); end
  endtask

  initial begin
    test_reset();
    test_basic_burst();
    test_missed_and_live_update();
    test_disabled_and_saturation();
    test_abort();
    test_reset_mid_burst();
    test_clear_race();
    test_unmapped();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/red_pitaya_sort_pulser.md
# red_pitaya_sort_pulser

Actuator end of the droplet-sorting path. Consumes the sort trigger from the FADS detector and, after a programmable delay, drives a bipolar square-wave burst onto a 14-bit signed DAC sample stream, which the external high-voltage amplifier uses to deflect the droplet. Configuration and statistics are exposed on the Red Pitaya system bus. The block sits between the FADS detector's `sort_trig` output and a DAC channel mux.

## Interface
- `DWT`, 14: DAC sample and amplitude width (signed).
- `MEM`, 32: width of the delay register and the counters.
- `adc_clk_i` input 1: sole clock; everything is sampled on its rising edge.
- `adc_rst_i` input 1: synchronous, active-high reset.
- `sort_trig_i` input 1: sort request, level input; only its rising edge is used.
- `dac_o` output DWT: signed DAC sample, registered.
- `busy_o` output 1: high from trigger acceptance to burst end.
- `sys_addr` input 32: bus address; bits [19:0] are decoded.
- `sys_wdata` input 32: bus write data.
- `sys_sel` input 4: byte select, ignored (full-word writes only).
- `sys_wen` input 1: bus write enable.
- `sys_ren` input 1: bus read enable.
- `sys_rdata` output 32: bus read data.
- `sys_err` output 1: always 0.
- `sys_ack` output 1: bus acknowledge.

## Operation
- Register map (offsets on `sys_addr[19:0]`):
  - 0x00 CTRL: bit0 `enable` (RW). bit1 `abort`, write-one, self-clearing, reads 0.
  - 0x04 DELAY: cycles from trigger to burst, MEM bits.
  - 0x08 HALF_PERIOD: 16 bits; 0 is treated as 1.
  - 0x0C N_CYCLES: full periods per burst, 16 bits; 0 is treated as 1.
  - 0x10 AMPLITUDE: signed DWT bits, sign-extended on read.
  - 0x14 PULSE_COUNT: read-only; any write clears it.
  - 0x18 MISSED_COUNT: read-only; any write clears it.
  - 0x1C STATUS: bit0 busy, bits[2:1] state.
  - Unmapped addresses read 0.
- Register reset defaults:
  - enable 0
  - DELAY 0
  - HALF_PERIOD 6250
  - N_CYCLES 10
  - AMPLITUDE 4096
  - both counters 0
- Edge detect: `trig_edge = sort_trig_i & ~sort_trig_q`, where `sort_trig_q` is the registered previous sample. `sort_trig_q` resets to 0.
- States:
  - IDLE (0): `dac_o` = 0.
    - On `trig_edge && enable`: snapshot DELAY, HALF_PERIOD, N_CYCLES and AMPLITUDE into shadow registers, increment PULSE_COUNT, go to DELAY.
    - On `trig_edge && !enable`: ignored, no count.
  - DELAY (1): count down the shadow delay; go to BURST after exactly D cycles in this state. With D = 0, go directly on the next cycle.
  - BURST (2):
    - Output `+amp` for H cycles, then `-amp` for H cycles; repeat N times.
    - After the last `-amp` sample, go to IDLE.
- `-amp` is computed in DWT+1 bits and saturated. AMPLITUDE = -8192 gives `+amp` = 8191 clamped and `-amp` = 8191 (sign flip, saturated). AMPLITUDE = 8191 gives ±8191.
- `busy_o` is 1 in DELAY and BURST, and 0 in IDLE.
- Any `trig_edge` while busy (regardless of enable) increments MISSED_COUNT and does not restart the burst.
- Bus writes during a burst update the live registers only; they take effect at the next accepted trigger.
- Abort: the cycle after the write, state is IDLE and `dac_o` = 0. A `trig_edge` in the same cycle as the abort write is ignored.
- Clearing a counter in the same cycle it would increment: clear wins, and the result is 0.
- Counters wrap at 2^MEM.
- Clearing `enable` mid-burst does not stop the burst.

## Timing
- Trigger at cycle T (first cycle `sort_trig_i` is sampled high):
  - DELAY state at T+1.
  - First `+amp` on `dac_o` at T+1+D.
  - `dac_o` returns to 0 and `busy_o` drops at T+1+D+2·H·N.
- The earliest next accepted edge is sampled in that same return cycle.
- A trigger edge on the final BURST cycle counts as missed.
- Bus timing:
  - `sys_ack` = `sys_en` (`sys_wen|sys_ren`), registered, so it asserts one cycle after the request.
  - `sys_rdata` is valid with `sys_ack`.
  - Write data is captured in the request cycle.
- Reset, taking effect on the next edge:
  - `dac_o` = 0, `busy_o` = 0, `sys_ack` = 0, `sys_err` = 0, `sys_rdata` = 0.
  - State = IDLE, and register defaults reload.
  - Reset mid-burst terminates the burst immediately.

## Test plan
- Reset, read all registers → defaults as listed; `dac_o` = 0, `busy_o` = 0.
- enable = 1, D = 3, H = 2, N = 2, A = 100; trigger rising edge at T → `dac_o` = 0 through T+3, then 100,100,−100,−100,100,100,−100,−100 on T+4..T+11, 0 at T+12; PULSE_COUNT = 1.
- During the above burst, pulse `sort_trig_i` twice and write AMPLITUDE = 50 → burst unchanged; MISSED_COUNT = 2; next burst uses ±50.
- enable = 0, trigger → no output, both counters unchanged. Then AMPLITUDE = −8192, H = 0, N = 0, enable = 1, D = 0 → one-cycle 8191 at T+1, one-cycle 8191 at T+2, 0 at T+3.
- Mid-burst CTRL write 0x3 → IDLE and `dac_o` = 0 on the next cycle. Mid-burst `adc_rst_i` pulse → same, plus counters = 0 and enable = 0.
- Write PULSE_COUNT in the same cycle as an accepted trigger → reads 0. A read of 0x20 → 0, with `sys_ack` high one cycle after `sys_ren`.
